// File: rtl/dice_game_mp.sv
// dice_game_mp: multi-player craps controller (roll handshake, point phase, roll limit, shooter rotation, saturating win scores)
module dice_game_mp #(
  parameter int SUM_W = 4,
  parameter int PLAYERS = 2,
  parameter int MAX_ROLLS = 15,
  parameter int CNT_W = 8,
  localparam int PW = PLAYERS > 1 ? $clog2(PLAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rb,
  input  logic                     new_game,
  input  logic                     sum_valid,
  input  logic [SUM_W-1:0]         sum,
  output logic                     roll,
  output logic                     win,
  output logic                     lose,
  output logic                     err,
  output logic [2:0]               state,
  output logic [SUM_W-1:0]         point,
  output logic [CNT_W-1:0]         roll_cnt,
  output logic [PW-1:0]            player,
  output logic [PLAYERS*CNT_W-1:0] score
);
  localparam logic [2:0] S0 = 3'b000, S1 = 3'b001, S2 = 3'b010, S3 = 3'b011, S4 = 3'b100, S5 = 3'b101;
  logic rb_q, rise, legal, ok, lim, err_n;
  logic [2:0] nxt;
  logic [CNT_W-1:0] cnt_inc;
  assign rise = rb & ~rb_q;
  assign legal = sum >= SUM_W'(2) && sum <= SUM_W'(12);
  assign ok = sum_valid & legal;
  assign cnt_inc = roll_cnt == '1 ? roll_cnt : roll_cnt + 1'b1;
  assign lim = (MAX_ROLLS != 0) && (cnt_inc == CNT_W'(MAX_ROLLS));
  assign err_n = sum_valid & ~legal & ~new_game & (state == S1 || state == S5);
  always_comb begin
    nxt = S0;
    case (state)
      S0: nxt = rise ? S1 : S0;
      S4: nxt = rise ? S5 : S4;
      S1: nxt = !ok ? S1 : (sum == SUM_W'(7) || sum == SUM_W'(11)) ? S2 :
                (sum == SUM_W'(2) || sum == SUM_W'(3) || sum == SUM_W'(12)) ? S3 : S4;
      S5: nxt = !ok ? S5 : sum == point ? S2 : (sum == SUM_W'(7) || lim) ? S3 : S4;
      S2: nxt = S2;
      S3: nxt = S3;
      default: nxt = S0;
    endcase
    if (new_game) nxt = S0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_q <= 1'b0;
      state <= S0;
      roll <= 1'b0;
      win <= 1'b0;
      lose <= 1'b0;
      err <= 1'b0;
      point <= '0;
      roll_cnt <= '0;
      player <= '0;
      score <= '0;
    end else begin
      rb_q <= rb;
      state <= nxt;
      roll <= nxt == S1 || nxt == S5;
      win <= nxt == S2;
      lose <= nxt == S3;
      err <= err_n;
      if (new_game) begin
        point <= '0;
        roll_cnt <= '0;
        if (state == S2 || state == S3) player <= player == PW'(PLAYERS - 1) ? '0 : player + 1'b1;
      end else begin
        if (state == S1 && nxt == S4) begin
          point <= sum;
          roll_cnt <= '0;
        end
        if (state == S5 && ok) roll_cnt <= cnt_inc;
      end
      for (int i = 0; i < PLAYERS; i++)
        if (nxt == S2 && state != S2 && player == PW'(i) && score[i*CNT_W +: CNT_W] != '1)
          score[i*CNT_W +: CNT_W] <= score[i*CNT_W +: CNT_W] + 1'b1;
    end
  end
endmodule
